// File: rtl/alarm_buzzer_pkg.sv
// Constants shared by the timer, display and buzzer blocks so they agree on
// state encodings and the system clock frequency.
package alarm_buzzer_pkg;

  localparam int DEFAULT_CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } buzz_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_buzzer_tone_gen.sv
// Square-wave divider: wave toggles every HALF enabled clk cycles and is held
// at 0 while cleared or disabled.
module tone_gen
  import alarm_buzzer_pkg::*;
#(
  parameter int HALF = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wave
);

  localparam int CNT_W = cnt_width(HALF);

  logic [CNT_W-1:0] cnt;
  logic             phase;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_W'(HALF - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign wave = phase;

endmodule

// File: rtl/alarm_buzzer.sv
// Plays BEEP_COUNT tone bursts on each genuine rising edge of flag_done;
// silence or flag_done falling aborts the pattern at once.
module alarm_buzzer
  import alarm_buzzer_pkg::*;
#(
  parameter int CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int TONE_HZ    = 2000,
  parameter int BEEP_MS    = 200,
  parameter int GAP_MS     = 200,
  parameter int BEEP_COUNT = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1khz,
  input  logic flag_done,
  input  logic silence,
  output logic buzzer,
  output logic active
);

  localparam int HALF   = CLK_HZ / (2 * TONE_HZ);
  localparam int MS_MAX = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;
  localparam int MS_W   = cnt_width(MS_MAX);
  localparam int BEEP_W = $clog2(BEEP_COUNT) + 1;

  buzz_state_t       state, state_next;
  logic [MS_W-1:0]   ms_cnt, ms_next;
  logic [BEEP_W-1:0] beep_cnt, beep_next;
  logic              flag_prev;
  logic              rise;
  logic              tone_en, tone_clr, tone_wave;

  assign rise     = flag_done & ~flag_prev;
  assign tone_en  = (state == ON);
  assign tone_clr = (state_next == ON) && (state != ON);

  tone_gen #(
    .HALF(HALF)
  ) u_tone (
    .clk (clk),
    .rst (rst),
    .en  (tone_en),
    .clr (tone_clr),
    .wave(tone_wave)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ms_cnt    <= '0;
      beep_cnt  <= '0;
      flag_prev <= 1'b1;
      buzzer    <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_next;
      ms_cnt    <= ms_next;
      beep_cnt  <= beep_next;
      flag_prev <= flag_done;
      buzzer    <= (state_next == ON) & tone_wave;
      active    <= (state_next != IDLE);
    end
  end

  // Abort takes priority over pattern timing in both ON and GAP.
  always_comb begin
    state_next = state;
    ms_next    = ms_cnt;
    beep_next  = beep_cnt;
    case (state)
      IDLE: begin
        if (rise && !silence) begin
          state_next = ON;
          ms_next    = '0;
          beep_next  = '0;
        end
      end
      ON: begin
        if (silence || !flag_done) begin
          state_next = IDLE;
          ms_next    = '0;
        end else if (tick_1khz) begin
          if (ms_cnt == MS_W'(BEEP_MS - 1)) begin
            ms_next = '0;
            if (beep_cnt == BEEP_W'(BEEP_COUNT - 1)) begin
              state_next = IDLE;
            end else begin
              beep_next  = beep_cnt + BEEP_W'(1);
              state_next = GAP;
            end
          end else begin
            ms_next = ms_cnt + MS_W'(1);
          end
        end
      end
      GAP: begin
        if (silence || !flag_done) begin
          state_next = IDLE;
          ms_next    = '0;
        end else if (tick_1khz) begin
          if (ms_cnt == MS_W'(GAP_MS - 1)) begin
            ms_next    = '0;
            state_next = ON;
          end else begin
            ms_next = ms_cnt + MS_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        ms_next    = '0;
        beep_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_alarm_buzzer.sv
// Directed bench for alarm_buzzer with HALF=5, 3 ms bursts, 2 ms gaps and two
// bursts per pattern; ticks land on edges whose index is 5 mod 10.
module tb_alarm_buzzer;

  localparam int CLK_HZ     = 40;
  localparam int TONE_HZ    = 4;
  localparam int BEEP_MS    = 3;
  localparam int GAP_MS     = 2;
  localparam int BEEP_COUNT = 2;

  logic clk = 1'b0;
  logic rst;
  logic tick_1khz;
  logic flag_done;
  logic silence;
  logic buzzer;
  logic active;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int idle_highs;

  logic buz_log [0:99];
  logic act_log [0:99];

  always #5 clk = ~clk;

  alarm_buzzer #(
    .CLK_HZ    (CLK_HZ),
    .TONE_HZ   (TONE_HZ),
    .BEEP_MS   (BEEP_MS),
    .GAP_MS    (GAP_MS),
    .BEEP_COUNT(BEEP_COUNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1khz(tick_1khz),
    .flag_done(flag_done),
    .silence  (silence),
    .buzzer   (buzzer),
    .active   (active)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive inputs for the coming edge, then advance one clock; the 1 kHz tick
  // is scheduled so that it is sampled on edges numbered 5 mod 10.
  task automatic applyStimulus(input logic flag, input logic sil);
    flag_done = flag;
    silence   = sil;
    @(posedge clk);
    #1;
    cyc++;
    tick_1khz = (((cyc + 1) % 10) == 5);
  endtask

  task automatic alignTo(input int lead, input logic flag);
    while (((cyc + lead) % 10) != 0) applyStimulus(flag, 1'b0);
  endtask

  // Edge k of the run samples flag_done high (unless dropped) and silence at k.
  task automatic runPattern(input int n, input int silence_at, input int drop_at);
    for (int k = 0; k < n; k++) begin
      applyStimulus((drop_at < 0) || (k < drop_at), k == silence_at);
      buz_log[k] = buzzer;
      act_log[k] = active;
    end
  endtask

  function automatic int countAct(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(act_log[k]);
    return c;
  endfunction

  function automatic int countBuz(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(buz_log[k]);
    return c;
  endfunction

  function automatic int countRises(input int hi);
    int c = 0;
    for (int k = 1; k <= hi; k++) c += int'(buz_log[k] && !buz_log[k-1]);
    return c;
  endfunction

  initial begin
    rst       = 1'b1;
    tick_1khz = 1'b0;
    flag_done = 1'b0;
    silence   = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("reset_buzzer", int'(buzzer), 0);
    checkOutput("reset_active", int'(active), 0);
    rst = 1'b0;
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_buzzer", int'(buzzer), 0);
    checkOutput("post_reset_active", int'(active), 0);

    // Full pattern: bursts on edges 0..24 and 45..74, gap 25..44.
    alignTo(1, 1'b0);
    checkOutput("pre_trigger_active", int'(active), 0);
    runPattern(90, -1, -1);
    checkOutput("full_active_latency", int'(act_log[0]), 1);
    checkOutput("full_buz_5", int'(buz_log[5]), 0);
    checkOutput("full_buz_6", int'(buz_log[6]), 1);
    checkOutput("full_buz_10", int'(buz_log[10]), 1);
    checkOutput("full_buz_11", int'(buz_log[11]), 0);
    checkOutput("full_buz_16", int'(buz_log[16]), 1);
    checkOutput("full_buz_21", int'(buz_log[21]), 0);
    checkOutput("full_gap_silent", countBuz(25, 45), 0);
    checkOutput("full_buz_71", int'(buz_log[71]), 1);
    checkOutput("full_buz_75", int'(buz_log[75]), 0);
    checkOutput("full_active_74", int'(act_log[74]), 1);
    checkOutput("full_active_75", int'(act_log[75]), 0);
    checkOutput("full_active_cycles", countAct(0, 89), 75);
    checkOutput("full_buz_high_cycles", countBuz(0, 89), 24);
    checkOutput("full_buz_rises", countRises(89), 5);
    checkOutput("full_no_rearm", int'(act_log[89]), 0);

    // Silence sampled on edge 8 while the tone is high.
    applyStimulus(1'b0, 1'b0);
    alignTo(1, 1'b0);
    runPattern(50, 8, -1);
    checkOutput("sil_buz_before", int'(buz_log[7]), 1);
    checkOutput("sil_act_before", int'(act_log[7]), 1);
    checkOutput("sil_buz_after", int'(buz_log[8]), 0);
    checkOutput("sil_act_after", int'(act_log[8]), 0);
    checkOutput("sil_no_restart", countAct(8, 49), 0);

    // flag_done drops on edge 30, inside the gap.
    applyStimulus(1'b0, 1'b0);
    alignTo(1, 1'b0);
    runPattern(50, -1, 30);
    checkOutput("drop_act_29", int'(act_log[29]), 1);
    checkOutput("drop_act_30", int'(act_log[30]), 0);
    checkOutput("drop_buz_30", int'(buz_log[30]), 0);
    checkOutput("drop_active_cycles", countAct(0, 49), 30);
    alignTo(1, 1'b0);
    runPattern(90, -1, -1);
    checkOutput("refire_active_cycles", countAct(0, 89), 75);
    checkOutput("refire_buz_rises", countRises(89), 5);

    // flag_done high through reset release must not trigger.
    rst = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b0);
    rst = 1'b0;
    idle_highs = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0);
      idle_highs += int'(active) + int'(buzzer);
    end
    checkOutput("held_flag_no_pattern", idle_highs, 0);
    alignTo(2, 1'b1);
    applyStimulus(1'b0, 1'b0);
    runPattern(90, -1, -1);
    checkOutput("held_retrigger_latency", int'(act_log[0]), 1);
    checkOutput("held_retrigger_cycles", countAct(0, 89), 75);
    checkOutput("held_retrigger_rises", countRises(89), 5);

    // Silence coincident with the rising edge suppresses the pattern.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("coinc_active", int'(active), 0);
    checkOutput("coinc_buzzer", int'(buzzer), 0);
    idle_highs = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0);
      idle_highs += int'(active) + int'(buzzer);
    end
    checkOutput("coinc_stays_idle", idle_highs, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alarm_buzzer.md
Name: alarm_buzzer

Overview:
- Downstream consumer of the countdown timer's flag_done output.
- On each genuine 0->1 transition of flag_done it plays a finite beep pattern on a piezo/buzzer pin: BEEP_COUNT tone bursts of BEEP_MS, separated by GAP_MS of silence.
- Pattern timing uses the already-synchronised 1 kHz tick pulse. The audible tone is divided from clk.
- A silence pulse (debounced button fall) or flag_done dropping low stops the pattern immediately.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TONE_HZ, 2000, buzzer square-wave frequency in Hz. HALF = CLK_HZ/(2*TONE_HZ) must be >= 1.
- BEEP_MS, 200, length of each tone burst in 1 kHz ticks (>= 1).
- GAP_MS, 200, silence between bursts in 1 kHz ticks (>= 1).
- BEEP_COUNT, 5, number of bursts per pattern (>= 1).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- tick_1khz  in  1  single-clk-cycle pulse once per ms, already in the clk domain.
- flag_done  in  1  level from the timer. High means countdown finished.
- silence  in  1  single-cycle pulse, e.g. a synchronised button falling edge.
- buzzer  out  1  registered square-wave drive. Low when not sounding.
- active  out  1  registered. High while a pattern is in progress (ON or GAP).

Behaviour:
- Reset: state=IDLE, buzzer=0, active=0, ms_cnt=0, beep_cnt=0, tone phase=0, flag_prev=1.
  - flag_prev resets to 1 so that a flag_done already high at reset release does NOT trigger a pattern.
- Edge detect: rise = flag_done & ~flag_prev. flag_prev <= flag_done every cycle.
- States: IDLE, ON, GAP.
- IDLE:
  - rise & ~silence -> ON next cycle, with ms_cnt=0, beep_cnt=0, tone counter and phase cleared.
  - active=1 from that next cycle (1-cycle latency from the edge sample).
- ON:
  - Tone counter counts clk cycles 0..HALF-1; at HALF-1 it wraps and the phase toggles.
  - buzzer <= phase, so the first high comes HALF cycles after entry.
  - Only on tick_1khz: if ms_cnt==BEEP_MS-1 then ms_cnt<=0 and
    - if beep_cnt==BEEP_COUNT-1 -> IDLE,
    - else beep_cnt++ and -> GAP.
  - Otherwise on tick_1khz, ms_cnt++.
- GAP:
  - buzzer=0.
  - On tick_1khz with ms_cnt==GAP_MS-1: ms_cnt<=0, tone cleared, -> ON. Otherwise on tick_1khz, ms_cnt++.
- Tick phase is unaligned to the trigger, so a burst lasts between BEEP_MS-1 and BEEP_MS ms. The same applies to gaps. This is accepted.
- Abort, highest priority after rst: silence=1 OR flag_done=0 while in ON/GAP -> IDLE next cycle, with buzzer=0 and active=0 in that cycle.
- Simultaneous silence and rise in IDLE: stays IDLE, no pattern.
- Retrigger while active is impossible without a falling edge first, and a falling edge aborts. After an abort, a new 0->1 edge starts a fresh pattern from beep 0.
- Pattern end: after the last burst the block returns to IDLE; it does not re-arm until flag_done falls and rises again.
- Counter widths:
  - ms_cnt: clog2(max(BEEP_MS,GAP_MS)).
  - beep_cnt: clog2(BEEP_COUNT)+1.
  - tone counter: clog2(HALF).
  - No counter may wrap past its terminal value.
- buzzer and active are driven from registers only; there are no combinational output paths.

Decomposition:
- Shared constants file: state encodings (IDLE=2'd0, ON=2'd1, GAP=2'd2) and default CLK_HZ, so the timer, display and buzzer blocks agree on the clock frequency.
- One sub-module: tone_gen, a square-wave divider.
  - Ports: clk, rst, en, clr, wave.
  - Parameter: HALF.
  - wave holds 0 while clr=1 or en=0.
- alarm_buzzer contains the FSM, the edge detector, the ms/beep counters and the output registers.

Test Plan:
Bench parameters: CLK_HZ=40, TONE_HZ=4 (HALF=5), BEEP_MS=3, GAP_MS=2, BEEP_COUNT=2. tick_1khz is pulsed every 10 clk.
- Reset: rst high for 3 cycles -> buzzer=0, active=0. rst low with flag_done=0 -> outputs stay 0.
- Full pattern: flag_done 0->1 -> active=1 one cycle later.
  - buzzer toggles every 5 clk during each burst.
  - Sequence is burst (~3 ticks), gap (~2 ticks) with buzzer=0, burst, then IDLE: active=0, exactly 2 bursts.
- Silence mid-burst: silence pulse during burst 1 -> next cycle buzzer=0 and active=0. flag_done stays high -> no restart.
- flag_done drops mid-gap -> IDLE next cycle. flag_done raised again -> fresh pattern with 2 bursts.
- flag_done held high across reset release -> no pattern. Then drive 0 for 1 cycle and back to 1 -> pattern starts.
- silence and the rising edge of flag_done in the same cycle -> active stays 0 and buzzer stays 0.
